cva6_boot_ctrl: RTL



---
 rtl/core_v_mcu_pkg.sv | 8 +
 rtl/cva6_boot_ctrl_pkg.sv | 24 ++
 rtl/cva6_boot_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/core_v_mcu_pkg.sv
// SoC-level address map constants shared across core_v_mcu blocks.
`timescale 1ns/1ps
package core_v_mcu_pkg;

   localparam logic [31:0] BOOT_ROM_REG_START_ADDR = 32'h1A00_0000;
   localparam logic [31:0] CODE_ZONE_BASE_ADDR     = 32'h1C00_8080;

endpackage

// File: rtl/cva6_boot_ctrl_pkg.sv
// Types and helpers for the CVA6 boot/reset sequencer.
`timescale 1ns/1ps
package cva6_boot_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT_ROM   = 2'd0,
      BOOT_CODE  = 2'd1,
      BOOT_DEBUG = 2'd2,
      BOOT_SW    = 2'd3
   } boot_sel_e;

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      LATCH   = 3'd1,
      RELEASE = 3'd2,
      RUN     = 3'd3,
      DRAIN   = 3'd4
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cva6_boot_ctrl.sv
// Reset/boot sequencer for the CVA6 core: hold, latch straps, release,
// optional debug halt, and drained restarts.
`timescale 1ns/1ps
module cva6_boot_ctrl
   import cva6_boot_ctrl_pkg::*;
#(
   parameter int              XLEN            = 64,
   parameter int              RST_HOLD_CYCLES = 16,
   parameter int              DRAIN_TIMEOUT   = 1024,
   parameter logic [XLEN-1:0] BOOT_ROM_ADDR   = XLEN'(core_v_mcu_pkg::BOOT_ROM_REG_START_ADDR),
   parameter logic [XLEN-1:0] CODE_ZONE_ADDR  = XLEN'(core_v_mcu_pkg::CODE_ZONE_BASE_ADDR)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [1:0]      boot_sel_i,
   input  logic [XLEN-1:0] sw_boot_addr_i,
   input  logic            sw_restart_req_i,
   input  logic            ndmreset_i,
   input  logic            axi_idle_i,
   input  logic            debug_halted_i,
   output logic            core_rst_no,
   output logic [XLEN-1:0] boot_addr_o,
   output logic            debug_req_o,
   output logic            running_o,
   output logic            drain_timeout_o,
   output logic [7:0]      restart_cnt_o
);

   localparam int CNT_W = $clog2(max_int(RST_HOLD_CYCLES, DRAIN_TIMEOUT)) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
   localparam logic [XLEN-1:0]  RVC_MASK   = ~XLEN'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  boot_addr_q, boot_addr_d;
   logic             dbg_mode_q, dbg_mode_d;
   logic             drain_timeout_q, drain_timeout_d;
   logic [7:0]       restart_cnt_q, restart_cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= HOLD;
         cnt_q           <= '0;
         boot_addr_q     <= BOOT_ROM_ADDR;
         dbg_mode_q      <= 1'b0;
         drain_timeout_q <= 1'b0;
         restart_cnt_q   <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         boot_addr_q     <= boot_addr_d;
         dbg_mode_q      <= dbg_mode_d;
         drain_timeout_q <= drain_timeout_d;
         restart_cnt_q   <= restart_cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      boot_addr_d     = boot_addr_q;
      dbg_mode_d      = dbg_mode_q;
      drain_timeout_d = drain_timeout_q;
      restart_cnt_d   = restart_cnt_q;

      case (state_q)
         HOLD: begin
            if (ndmreset_i) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = LATCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LATCH: begin
            case (boot_sel_e'(boot_sel_i))
               BOOT_CODE: boot_addr_d = CODE_ZONE_ADDR;
               BOOT_SW:   boot_addr_d = sw_boot_addr_i & RVC_MASK;
               default:   boot_addr_d = BOOT_ROM_ADDR;
            endcase
            dbg_mode_d = (boot_sel_e'(boot_sel_i) == BOOT_DEBUG);
            state_d    = RELEASE;
         end
         RELEASE: begin
            if (!dbg_mode_q || debug_halted_i) state_d = RUN;
         end
         RUN: begin
            if (ndmreset_i)            state_d = HOLD;
            else if (sw_restart_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            // An idle bus in the last timeout cycle counts as a clean drain.
            if (ndmreset_i || axi_idle_i) begin
               state_d = HOLD;
            end else if (cnt_q == DRAIN_LAST) begin
               state_d         = HOLD;
               drain_timeout_d = 1'b1;
            end
         end
         default: state_d = HOLD;
      endcase

      if (state_d != state_q) cnt_d = '0;

      if ((state_q == RUN || state_q == DRAIN) && state_d == HOLD &&
          restart_cnt_q != 8'hFF) begin
         restart_cnt_d = restart_cnt_q + 8'd1;
      end
   end

   assign core_rst_no     = (state_q == RELEASE) || (state_q == RUN) || (state_q == DRAIN);
   assign boot_addr_o     = boot_addr_q;
   assign debug_req_o     = (state_q == RELEASE) && dbg_mode_q;
   assign running_o       = (state_q == RUN);
   assign drain_timeout_o = drain_timeout_q;
   assign restart_cnt_o   = restart_cnt_q;

endmodule
